// File: rtl/itof_issue_queue_if.sv
// itof_issue_queue_if: request/response bundle of the itof issue queue.
// master = request producer / writeback consumer, slave = the issue queue.
interface itof_issue_queue_if #(
  parameter int TAG_W = 5
);
  // request side (integer register read -> queue)
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  // result side (queue -> FP register-file writeback)
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );
endinterface

// File: rtl/itof_issue_queue.sv
// itof_issue_queue: small FIFO of int->float requests feeding a combinational
// itof converter whose result is held in a valid/ready output register.
// Optional feature macro: FCVT_PERF_EN adds the stall_cnt output (cycles with
// out_valid & !out_ready, saturating, cleared only by reset).

// Combinational signed int32 -> IEEE-754 single, mantissa truncated.
// The magnitude is kept to 31 bits, so 0x80000000 collapses to zero; this
// matches the legacy converter bit for bit and is kept on purpose.
module itof_issue_queue_cvt (
  input  logic [31:0] x_i,
  output logic [31:0] y_o
);
  logic        sign;
  logic [30:0] mag;
  logic [4:0]  msb;
  logic [30:0] norm;
  logic [22:0] mant;
  logic [7:0]  expo;

  // Find the leading one, normalise it to bit 30, drop it and truncate.
  always_comb begin
    sign = x_i[31];
    mag  = 31'(sign ? (~x_i + 32'd1) : x_i);
    msb  = '0;
    for (int i = 0; i < 31; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm = mag << (5'd30 - msb);
    mant = 23'(norm >> 7);
    expo = 8'd127 + {3'b000, msb};
    if (mag == '0) y_o = '0;
    else           y_o = {sign, expo, mant};
  end
endmodule

module itof_issue_queue #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  itof_issue_queue_if.slave   io
`ifdef FCVT_PERF_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]      x;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_y_q, out_y_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             in_ready;
  logic             push;
  logic             ld;
  req_t             head;
  logic [31:0]      cvt_y;

  // Accept only on free space; no full-bypass even when popping this cycle.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = io.in_valid & in_ready;
  // Refill the result register whenever it is empty or being consumed.
  assign ld       = (count_q != '0) & (~out_valid_q | io.out_ready);
  assign head     = mem_q[rd_ptr_q];

  itof_issue_queue_cvt u_cvt (
    .x_i (head.x),
    .y_o (cvt_y)
  );

  // Entry storage; no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= '{x: io.in_x, tag: io.in_tag};
  end

  // Pointer/occupancy next state; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (ld)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, ld})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result register next state: load, drain, or hold under stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (ld) begin
      out_valid_d = 1'b1;
      out_y_d     = cvt_y;
      out_tag_d   = head.tag;
    end else if (out_valid_q && io.out_ready) begin
      out_valid_d = 1'b0;   // drained with nothing behind it; data holds
    end
  end

  // Result register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_y     = out_y_q;
  assign io.out_tag   = out_tag_q;

`ifdef FCVT_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count writeback back-pressure cycles, saturating; flush does not clear.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !io.out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_itof_issue_queue.sv
// tb_itof_issue_queue: directed + random stimulus; accepted requests are
// pushed into an expected-result queue and a negedge monitor pops/compares
// every handshaked result.
module tb_itof_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  itof_issue_queue_if #(.TAG_W(TAG_W)) ifc ();

`ifdef FCVT_PERF_EN
  logic [31:0] stall_cnt;
`endif

  itof_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .io    (ifc.slave)
`ifdef FCVT_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [31+TAG_W:0] exp_q [$];
  logic [31+TAG_W:0] mon_e;

  // Reference conversion from the numeric definition: value = 2^e * (1 + f/2^23),
  // f = floor((|x| - 2^e) * 2^23 / 2^e).
  function automatic logic [31:0] ref_itof(input logic [31:0] x);
    longint m, frac;
    int     e;
    logic [7:0] ex;
    if (x == 32'h0 || x == 32'h8000_0000) return 32'h0;
    m = x[31] ? ((longint'(1) << 32) - longint'(x)) : longint'(x);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    frac = ((m - (longint'(1) << e)) << 23) >> e;
    ex = 8'(127 + e);
    return {x[31], ex, frac[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: values seen at negedge are those the next edge acts on.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() < DEPTH)      chk("in_ready_space", 32'(ifc.in_ready), 32'd1);
      if (exp_q.size() == DEPTH + 1) chk("in_ready_full",  32'(ifc.in_ready), 32'd0);
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%08h required=none", ifc.out_y);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_out_y",   ifc.out_y, mon_e[31+TAG_W:TAG_W]);
          chk("sb_out_tag", 32'(ifc.out_tag), 32'(mon_e[TAG_W-1:0]));
        end
      end
      if (flush) exp_q.delete();
      else if (ifc.in_valid && ifc.in_ready)
        exp_q.push_back({ref_itof(ifc.in_x), ifc.in_tag});
    end
  end

  // One request into an idle queue with out_ready=1; result due one edge later.
  task automatic push_check(input string name, input logic [31:0] x,
                            input logic [TAG_W-1:0] tag, input logic [31:0] y_req);
    ifc.in_valid = 1'b1;
    ifc.in_x     = x;
    ifc.in_tag   = tag;
    step();
    ifc.in_valid = 1'b0;
    step();
    chk({name, "_vld"}, 32'(ifc.out_valid), 32'd1);
    chk(name, ifc.out_y, y_req);
    chk({name, "_tag"}, 32'(ifc.out_tag), 32'(tag));
    step();
  endtask

  int acc;
  int cyc;
`ifdef FCVT_PERF_EN
  logic [31:0] base_cnt;
`endif

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_x      = '0;
    ifc.in_tag    = '0;
    ifc.out_ready = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_y",     ifc.out_y, 32'd0);
    chk("rst_out_tag",   32'(ifc.out_tag), 32'd0);
    rstn = 1'b1;
    step();
    chk("rst_in_ready",  32'(ifc.in_ready), 32'd1);

    // single requests and conversion corners
    ifc.out_ready = 1'b1;
    push_check("one",     32'd1,          5'd3,  32'h3F80_0000);
    push_check("neg_one", 32'hFFFF_FFFF,  5'd4,  32'hBF80_0000);
    push_check("zero",    32'd0,          5'd5,  32'h0000_0000);
    push_check("max_pos", 32'h7FFF_FFFF,  5'd6,  32'h4EFF_FFFF);
    push_check("min_neg", 32'h8000_0000,  5'd7,  32'h0000_0000);
    push_check("ten",     32'd10,         5'd8,  32'h4120_0000);
    push_check("neg_ten", 32'hFFFF_FFF6,  5'd9,  32'hC120_0000);
    push_check("trunc",   32'h0100_0003,  5'd10, 32'h4B80_0001);

    // fill under back-pressure, then release
    ifc.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_x     = 32'(10 * (i + 1));
      ifc.in_tag   = TAG_W'(i);
      if (ifc.in_ready) acc++;
      step();
    end
    ifc.in_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'(DEPTH + 1));
    chk("fill_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("fill_head_y",   ifc.out_y, 32'h4120_0000);
    ifc.out_ready = 1'b1;
    repeat (DEPTH + 3) step();
    chk("fill_drained", 32'(ifc.out_valid), 32'd0);

    // flush with 3 queued + result held, request offered in the flush cycle
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_x     = 32'(100 + i);
      ifc.in_tag   = TAG_W'(20 + i);
      step();
    end
    chk("pre_flush_valid", 32'(ifc.out_valid), 32'd1);
    flush        = 1'b1;
    ifc.in_x     = 32'd777;
    ifc.in_tag   = 5'd31;
    step();
    flush        = 1'b0;
    ifc.in_valid = 1'b0;
    chk("flush_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("flush_in_ready",  32'(ifc.in_ready), 32'd1);
    ifc.out_ready = 1'b1;
    repeat (4) step();
    chk("flush_dropped", 32'(ifc.out_valid), 32'd0);

`ifdef FCVT_PERF_EN
    // seven back-pressured cycles with a result held
    ifc.in_valid = 1'b1;
    ifc.in_x     = 32'd3;
    ifc.in_tag   = 5'd1;
    step();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    step();
    base_cnt = stall_cnt;
    repeat (7) step();
    chk("perf_stall_cnt", stall_cnt - base_cnt, 32'd7);
    ifc.out_ready = 1'b1;
    repeat (2) step();
`endif

    // random streaming with random back-pressure
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 3000) begin
      ifc.in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       ifc.in_x = 32'h8000_0000;
        1:       ifc.in_x = 32'h7FFF_FFFF;
        2:       ifc.in_x = 32'($urandom_range(0, 2)) - 32'd1;
        default: ifc.in_x = $urandom();
      endcase
      ifc.in_tag    = TAG_W'($urandom());
      ifc.out_ready = ($urandom_range(0, 1) != 0);
      if (ifc.in_valid && ifc.in_ready) acc++;
      step();
      cyc++;
    end
    ifc.in_valid = 1'b0;
    chk("stream_accepted", 32'(acc), 32'd100);

    // drain the stream before the reset scenario
    ifc.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("stream_drain", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in the middle of traffic
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_x     = 32'(55 + i);
      ifc.in_tag   = TAG_W'(i);
      step();
    end
    ifc.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(ifc.in_ready), 32'd1);
    step();
    rstn = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (5) step();
    chk("midrst_no_stale", 32'(ifc.out_valid), 32'd0);

    // final drain bound
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
